sdram_arbiter: RTL

Command arbiter and refresh scheduler for the single-port SDRAM. After power-up it passes through the initialisation engine's command stream. It then runs the periodic auto-refresh timer and grants the shared SDRAM command/address bus to one of three engines: auto-refresh, write burst or read burst. It drives the SDRAM command, address and bank pins through a state-selected multiplexer. It sits between the init/refresh/write/read engines and the SDRAM pin registers.

---
 rtl/sdram_arbiter_if.sv | 45 ++++
 rtl/sdram_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_if.sv
// Engine-side and pin-side signals of the SDRAM command arbiter.
// The slave modport is the arbiter; the master modport is the engines plus the pin registers.
interface sdram_arbiter_if;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        ref_end;
    logic [3:0]  ref_cmd;
    logic [11:0] ref_addr;
    logic        wr_req;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_bank;
    logic        rd_req;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        ref_en;
    logic        wr_en;
    logic        rd_en;
    logic        ref_req;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;

    modport slave (
        input  init_end, init_cmd, init_addr,
        input  ref_end, ref_cmd, ref_addr,
        input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
        input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
        output ref_en, wr_en, rd_en, ref_req,
        output sdram_cmd, sdram_addr, sdram_bank
    );

    modport master (
        output init_end, init_cmd, init_addr,
        output ref_end, ref_cmd, ref_addr,
        output wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
        output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
        input  ref_en, wr_en, rd_en, ref_req,
        input  sdram_cmd, sdram_addr, sdram_bank
    );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: init pass-through, periodic refresh scheduling and
// round-robin write/read grants, with a state-selected pin multiplexer.
module sdram_arbiter #(
    parameter int unsigned REF_PERIOD = 780
) (
    input  logic            clk,
    input  logic            rst,
    sdram_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CMD_W   = 4;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned BANK_W  = 2;
    localparam logic [CMD_W-1:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARB   = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               last_wr_q, last_wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ref_req_q, ref_req_d;
    logic               ref_en_q, ref_en_d;
    logic               wr_en_q, wr_en_d;
    logic               rd_en_q, rd_en_d;
    logic               expire_c;
    logic [CMD_W-1:0]   cmd_c;
    logic [ADDR_W-1:0]  addr_c;
    logic [BANK_W-1:0]  bank_c;

    // Next state, one-cycle grants on state entry, round-robin history
    always_comb begin
        state_d   = state_q;
        unique case (state_q)
            S_INIT:  if (bus.init_end) state_d = S_ARB;
            S_ARB: begin
                if (ref_req_q)                     state_d = S_AREF;
                else if (bus.wr_req && bus.rd_req) state_d = last_wr_q ? S_READ : S_WRITE;
                else if (bus.wr_req)               state_d = S_WRITE;
                else if (bus.rd_req)               state_d = S_READ;
            end
            S_AREF:  if (bus.ref_end) state_d = S_ARB;
            S_WRITE: if (bus.wr_end)  state_d = S_ARB;
            S_READ:  if (bus.rd_end)  state_d = S_ARB;
            default: state_d = S_ARB;
        endcase

        ref_en_d  = (state_d == S_AREF)  && (state_q != S_AREF);
        wr_en_d   = (state_d == S_WRITE) && (state_q != S_WRITE);
        rd_en_d   = (state_d == S_READ)  && (state_q != S_READ);

        last_wr_d = last_wr_q;
        if (wr_en_d)      last_wr_d = 1'b1;
        else if (rd_en_d) last_wr_d = 1'b0;
    end

    // Refresh timer; an expiry coinciding with a refresh grant keeps the request set
    always_comb begin
        expire_c  = 1'b0;
        cnt_d     = cnt_q;
        if (state_d == S_INIT) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(REF_PERIOD - 1)) begin
            cnt_d    = '0;
            expire_c = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        ref_req_d = ref_req_q;
        if (expire_c)      ref_req_d = 1'b1;
        else if (ref_en_d) ref_req_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_INIT;
            last_wr_q <= 1'b0;
            cnt_q     <= '0;
            ref_req_q <= 1'b0;
            ref_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
            ref_req_q <= ref_req_d;
            ref_en_q  <= ref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
        end
    end

    // Pin multiplexer follows the registered state so the owning engine drives the pins directly
    always_comb begin
        cmd_c  = CMD_NOP;
        addr_c = '0;
        bank_c = '0;
        unique case (state_q)
            S_INIT: begin
                cmd_c  = bus.init_cmd;
                addr_c = bus.init_addr;
            end
            S_AREF: begin
                cmd_c  = bus.ref_cmd;
                addr_c = bus.ref_addr;
            end
            S_WRITE: begin
                cmd_c  = bus.wr_cmd;
                addr_c = bus.wr_addr;
                bank_c = bus.wr_bank;
            end
            S_READ: begin
                cmd_c  = bus.rd_cmd;
                addr_c = bus.rd_addr;
                bank_c = bus.rd_bank;
            end
            default: ;
        endcase
    end

    assign bus.ref_en     = ref_en_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.ref_req    = ref_req_q;
    assign bus.sdram_cmd  = cmd_c;
    assign bus.sdram_addr = addr_c;
    assign bus.sdram_bank = bank_c;
endmodule
